spi_regfile_bridge: RTL and testbench

- Clock-domain side of the SPI slave path.
- Takes completed frames from the SPI shift core (sck domain) and decodes a command/address/data word, giving a generic, parametrised register file.
- Outputs: NUM_REGS read/write control registers with per-register write strobes, one sticky status register, a saturating error counter and a constant ID register.
- Read data returns in the following SPI frame. This block replaces hard-coded per-peripheral address decoding for the GCD and Sobel front ends.

---
 rtl/spi_regfile_bridge.sv | 171 +++++++++++++++++
 tb/tb_spi_regfile_bridge.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_regfile_bridge.sv
// System-clock side of the SPI slave: synchronizes frame-complete/CS, decodes
// command/address/data words into a generic register file and stages read data.
module spi_regfile_bridge #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned NUM_REGS    = 8,
  parameter logic [31:0] ID_VALUE    = 32'h0000_5B01,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned FRAME_WIDTH = DATA_WIDTH + 8
) (
  input  logic                           clk_i,
  input  logic                           nreset_i,
  input  logic                           cs_n_async_i,
  input  logic                           rx_done_async_i,
  input  logic [FRAME_WIDTH-1:0]         rx_word_i,
  output logic [FRAME_WIDTH-1:0]         tx_word_o,
  output logic [NUM_REGS*DATA_WIDTH-1:0] ctrl_regs_o,
  output logic [NUM_REGS-1:0]            wr_strobe_o,
  input  logic [DATA_WIDTH-1:0]          status_i,
  input  logic                           status_valid_i,
  output logic                           frame_abort_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_DECODE = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [6:0] ADDR_ERR  = 7'h7D;
  localparam logic [6:0] ADDR_STAT = 7'h7E;
  localparam logic [6:0] ADDR_ID   = 7'h7F;

  logic [1:0]             state, next_state;
  logic [SYNC_STAGES-1:0] cs_sync, done_sync;
  logic                   done_d;
  logic                   cs_n_s, done_s, done_rise;
  logic                   abort_c;

  logic                   rnw_c;
  logic [6:0]             addr_c;
  logic [DATA_WIDTH-1:0]  wdata_c;
  logic                   reg_hit_c;
  logic [DATA_WIDTH-1:0]  rdata_c;
  logic                   msb_c;
  logic                   err_c;
  logic                   w1c_c;
  logic                   wr_reg_c;
  logic [FRAME_WIDTH-1:0] tx_next_c;
  logic                   decode;

  logic [FRAME_WIDTH-1:0] tx_hold;
  logic [DATA_WIDTH-1:0]  status_q;
  logic                   sticky;
  logic [7:0]             err_cnt;

  // Synchronizers; CS idles high so the FSM never sees a false select out of reset
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      cs_sync   <= '1;
      done_sync <= '0;
      done_d    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n_async_i};
      done_sync <= {done_sync[SYNC_STAGES-2:0], rx_done_async_i};
      done_d    <= done_sync[SYNC_STAGES-1];
    end
  end

  assign cs_n_s    = cs_sync[SYNC_STAGES-1];
  assign done_s    = done_sync[SYNC_STAGES-1];
  assign done_rise = done_s & ~done_d;
  assign decode    = (state == S_DECODE);

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) state <= S_IDLE;
    else           state <= next_state;
  end

  // A completed frame takes priority over a simultaneous CS release
  always_comb begin
    next_state = state;
    abort_c    = 1'b0;
    case (state)
      S_IDLE:   if (!cs_n_s) next_state = S_ACTIVE;
      S_ACTIVE: begin
        if (done_rise) begin
          next_state = S_DECODE;
        end else if (cs_n_s) begin
          abort_c    = 1'b1;
          next_state = S_IDLE;
        end
      end
      S_DECODE: next_state = S_RESP;
      S_RESP:   next_state = cs_n_s ? S_IDLE : S_ACTIVE;
      default:  next_state = S_IDLE;
    endcase
  end

  assign rnw_c     = rx_word_i[FRAME_WIDTH-1];
  assign addr_c    = rx_word_i[FRAME_WIDTH-2 -: 7];
  assign wdata_c   = rx_word_i[DATA_WIDTH-1:0];
  assign reg_hit_c = (32'(addr_c) < NUM_REGS);

  // Command decode and read-data selection, acted on only in S_DECODE
  always_comb begin
    rdata_c  = '0;
    msb_c    = rnw_c;
    err_c    = 1'b0;
    w1c_c    = 1'b0;
    wr_reg_c = 1'b0;
    if (rnw_c) begin
      if (reg_hit_c) begin
        for (int k = 0; k < NUM_REGS; k++)
          if (addr_c == 7'(k)) rdata_c = ctrl_regs_o[k*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        case (addr_c)
          ADDR_ERR:  rdata_c = DATA_WIDTH'(err_cnt);
          ADDR_STAT: begin
            rdata_c = status_q;
            msb_c   = sticky;
          end
          ADDR_ID:   rdata_c = DATA_WIDTH'(ID_VALUE);
          default:   err_c = 1'b1;
        endcase
      end
    end else begin
      if (reg_hit_c)                wr_reg_c = 1'b1;
      else if (addr_c == ADDR_STAT) w1c_c = wdata_c[0];
      else                          err_c = 1'b1;
    end
    tx_next_c = rnw_c ? {msb_c, addr_c, rdata_c} : {1'b0, addr_c, wdata_c};
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      ctrl_regs_o   <= '0;
      wr_strobe_o   <= '0;
      frame_abort_o <= 1'b0;
      tx_hold       <= '0;
      tx_word_o     <= '0;
      err_cnt       <= '0;
    end else begin
      wr_strobe_o   <= '0;
      frame_abort_o <= abort_c;
      if (decode) begin
        tx_hold <= tx_next_c;
        for (int k = 0; k < NUM_REGS; k++) begin
          if (wr_reg_c && addr_c == 7'(k)) begin
            ctrl_regs_o[k*DATA_WIDTH +: DATA_WIDTH] <= wdata_c;
            wr_strobe_o[k]                          <= 1'b1;
          end
        end
        if (err_c && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
      if (state == S_RESP) tx_word_o <= tx_hold;
    end
  end

  // Status capture runs in every state; a new result beats a same-cycle clear
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      status_q <= '0;
      sticky   <= 1'b0;
    end else if (status_valid_i) begin
      status_q <= status_i;
      sticky   <= 1'b1;
    end else if (decode && w1c_c) begin
      sticky   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_regfile_bridge.sv
// Self-checking bench for spi_regfile_bridge: directed table, status/abort/reset
// sequences and random frames against an address-map reference model.
module tb_spi_regfile_bridge;

  logic         clk = 1'b0;
  logic         nreset;
  logic         cs_n;
  logic         rx_done;
  logic [23:0]  rx_word;
  logic [23:0]  tx_word;
  logic [127:0] ctrl_regs;
  logic [7:0]   wr_strobe;
  logic [15:0]  status;
  logic         status_valid;
  logic         frame_abort;

  spi_regfile_bridge dut (
    .clk_i           (clk),
    .nreset_i        (nreset),
    .cs_n_async_i    (cs_n),
    .rx_done_async_i (rx_done),
    .rx_word_i       (rx_word),
    .tx_word_o       (tx_word),
    .ctrl_regs_o     (ctrl_regs),
    .wr_strobe_o     (wr_strobe),
    .status_i        (status),
    .status_valid_i  (status_valid),
    .frame_abort_o   (frame_abort)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int strobe_cnt = 0;
  int abort_cnt = 0;
  logic [7:0] strobe_last = '0;

  // Reference state: register file as an array, counters as plain integers
  logic [15:0] m_regs [8];
  int          m_err;
  logic [15:0] m_status;
  logic        m_sticky;

  typedef struct {
    logic [23:0] word;
    bit          last;
    logic [23:0] exp_tx;
  } vec_t;
  vec_t tbl [10];

  always @(negedge clk) begin
    if (wr_strobe != 8'h00) begin
      strobe_cnt++;
      strobe_last = wr_strobe;
    end
    if (frame_abort) abort_cnt++;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] flat();
    logic [127:0] f;
    for (int k = 0; k < 8; k++) f[k*16 +: 16] = m_regs[k];
    return f;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) m_regs[k] = '0;
    m_err    = 0;
    m_status = '0;
    m_sticky = 1'b0;
  endtask

  task automatic bump_err();
    m_err = (m_err < 255) ? m_err + 1 : 255;
  endtask

  task automatic model_xfer(input logic [23:0] w, output logic [23:0] etx, output logic [7:0] estb);
    logic        rnw;
    logic [6:0]  a;
    logic [15:0] d;
    int          ai;
    rnw  = w[23];
    a    = w[22:16];
    d    = w[15:0];
    ai   = int'(a);
    estb = '0;
    if (!rnw) begin
      etx = {1'b0, a, d};
      if (ai < 8) begin
        m_regs[ai] = d;
        estb       = 8'(1 << ai);
      end else if (ai == 126) begin
        if (d[0]) m_sticky = 1'b0;
      end else begin
        bump_err();
      end
    end else begin
      if (ai < 8)         etx = {1'b1, a, m_regs[ai]};
      else if (ai == 125) etx = {1'b1, a, 16'(m_err)};
      else if (ai == 126) etx = {m_sticky, a, m_status};
      else if (ai == 127) etx = {1'b1, a, 16'h5B01};
      else begin
        etx = {1'b1, a, 16'h0000};
        bump_err();
      end
    end
  endtask

  // One SPI frame; pc >= 0 pulses status_valid at that negedge of the frame
  task automatic xfer(input logic [23:0] w, input bit last, input int pc,
                      input logic [15:0] pv, output logic [23:0] got);
    logic [23:0] etx;
    logic [7:0]  estb;
    model_xfer(w, etx, estb);
    if (pc >= 0) begin
      m_status = pv;
      m_sticky = 1'b1;
    end
    if (cs_n) begin
      cs_n = 1'b0;
      repeat (4) @(negedge clk);
    end
    strobe_cnt = 0;
    abort_cnt  = 0;
    rx_word    = w;
    rx_done    = 1'b1;
    if (last) cs_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == pc) begin
        status       = pv;
        status_valid = 1'b1;
      end
      @(negedge clk);
      status_valid = 1'b0;
    end
    got = tx_word;
    chk("tx_word", 128'(got), 128'(etx));
    repeat (3) @(negedge clk);
    rx_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("ctrl_regs", ctrl_regs, flat());
    chk("strobe_count", 128'(strobe_cnt), 128'((estb != 8'h00) ? 1 : 0));
    if (estb != 8'h00) chk("strobe_value", 128'(strobe_last), 128'(estb));
    chk("no_abort", 128'(abort_cnt), 128'(0));
  endtask

  task automatic pulse_status(input logic [15:0] v);
    status       = v;
    status_valid = 1'b1;
    @(negedge clk);
    status_valid = 1'b0;
    m_status     = v;
    m_sticky     = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [23:0] got;
    logic [23:0] tx_before;
    logic [6:0]  ra;
    int          sel;

    tbl[0] = '{24'h03BEEF, 1'b0, 24'h03BEEF};
    tbl[1] = '{24'h031234, 1'b0, 24'h031234};
    tbl[2] = '{24'h830000, 1'b0, 24'h831234};
    tbl[3] = '{24'hFF0000, 1'b0, 24'hFF5B01};
    tbl[4] = '{24'h400000, 1'b0, 24'h400000};
    tbl[5] = '{24'h400005, 1'b0, 24'h400005};
    tbl[6] = '{24'h40ABCD, 1'b0, 24'h40ABCD};
    tbl[7] = '{24'hFD0000, 1'b0, 24'hFD0003};
    tbl[8] = '{24'h800000, 1'b0, 24'h800000};
    tbl[9] = '{24'hFE0000, 1'b1, 24'h7E0000};

    nreset       = 1'b0;
    cs_n         = 1'b1;
    rx_done      = 1'b0;
    rx_word      = '0;
    status       = '0;
    status_valid = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_tx", 128'(tx_word), 128'(0));
    chk("reset_ctrl", ctrl_regs, 128'(0));
    chk("reset_strobe", 128'(wr_strobe), 128'(0));
    chk("reset_abort", 128'(frame_abort), 128'(0));
    nreset = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      xfer(tbl[i].word, tbl[i].last, -1, '0, got);
      chk("table_tx", 128'(got), 128'(tbl[i].exp_tx));
    end

    // Sticky status: set, read, clear, and same-cycle set/clear ordering
    pulse_status(16'h0015);
    xfer(24'hFE0000, 1'b0, -1, '0, got);
    chk("status_read", 128'(got), 128'(24'hFE0015));
    xfer(24'h7E0001, 1'b0, -1, '0, got);
    xfer(24'hFE0000, 1'b0, -1, '0, got);
    chk("status_cleared", 128'(got), 128'(24'h7E0015));
    xfer(24'h7E0001, 1'b0, 3, 16'h0022, got);
    xfer(24'hFE0000, 1'b0, 3, 16'h0033, got);
    chk("set_beats_w1c", 128'(got), 128'(24'hFE0022));
    xfer(24'hFE0000, 1'b1, -1, '0, got);
    chk("post_capture", 128'(got), 128'(24'hFE0033));

    // Aborted frame: CS released before any completed word
    tx_before  = tx_word;
    abort_cnt  = 0;
    strobe_cnt = 0;
    cs_n = 1'b0;
    repeat (10) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_pulses", 128'(abort_cnt), 128'(1));
    chk("abort_tx", 128'(tx_word), 128'(tx_before));
    chk("abort_ctrl", ctrl_regs, flat());
    chk("abort_strobe", 128'(strobe_cnt), 128'(0));
    xfer(24'h025555, 1'b1, -1, '0, got);

    // Random traffic against the model
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 8)       ra = 7'(sel);
      else if (sel == 8) ra = 7'(125 + $urandom_range(0, 2));
      else               ra = 7'($urandom_range(8, 124));
      xfer({1'($urandom_range(0, 1)), ra, 16'($urandom)}, ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 5) == 0) ? 3 : -1, 16'($urandom), got);
    end

    // Error counter saturation
    for (int i = 0; i < 300; i++)
      xfer({1'b0, 7'h41, 16'(i)}, (i == 299), -1, '0, got);
    xfer(24'hFD0000, 1'b1, -1, '0, got);
    chk("err_saturated", 128'(got), 128'(24'hFD00FF));

    // Reset while a write to reg 1 is being decoded
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    strobe_cnt = 0;
    rx_word = 24'h01AAAA;
    rx_done = 1'b1;
    repeat (3) @(negedge clk);
    nreset  = 1'b0;
    cs_n    = 1'b1;
    rx_done = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ctrl", ctrl_regs, 128'(0));
    chk("rst_tx", 128'(tx_word), 128'(0));
    nreset = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_no_strobe", 128'(strobe_cnt), 128'(0));
    xfer(24'h810000, 1'b0, -1, '0, got);
    chk("rst_reg1", 128'(got), 128'(24'h810000));
    xfer(24'hFD0000, 1'b1, -1, '0, got);
    chk("rst_err", 128'(got), 128'(24'hFD0000));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
